// File: rtl/uart_axis_rx_pkg.sv
// Shared types for the UART receiver: frame phase decode and counter widths.
package uart_axis_rx_pkg;

  localparam int unsigned PRESCALE_CNT_W = 19;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_WAIT,
    PH_START,
    PH_DATA,
    PH_STOP
  } rx_phase_e;

  // The receiver state lives in bit_cnt; this names the phase it implies.
  function automatic rx_phase_e rx_phase(input logic        cnt_zero,
                                         input int unsigned bit_cnt,
                                         input int unsigned bit_cnt_start);
    if (!cnt_zero)                return PH_WAIT;
    if (bit_cnt == 0)             return PH_IDLE;
    if (bit_cnt == bit_cnt_start) return PH_START;
    if (bit_cnt == 1)             return PH_STOP;
    return PH_DATA;
  endfunction

endpackage

// File: rtl/uart_axis_rx_if.sv
// Stream handshake bundle carrying received words to the consumer.
interface uart_axis_rx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_axis_rx.sv
// UART receiver: start + DATA_WIDTH LSB-first data bits + stop, presented on a stream output.
module uart_axis_rx
  import uart_axis_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_axis_rx_if.master        output_axis,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 3);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_START = BIT_CNT_W'(DATA_WIDTH + 2);

  logic [DATA_WIDTH-1:0]     tdata_q;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic                      tvalid_q;
  logic                      busy_q;
  logic                      overrun_q;
  logic                      frame_q;
  logic                      rxd_q;
  logic [PRESCALE_CNT_W-1:0] prescale_cnt_q;
  logic [BIT_CNT_W-1:0]      bit_cnt_q;
  logic [PRESCALE_CNT_W-1:0] start_load;
  logic [PRESCALE_CNT_W-1:0] bit_load;
  rx_phase_e                 phase;

  // Half a bit to land mid start bit, then full bits between samples.
  assign start_load = {1'b0, prescale, 2'b00} - PRESCALE_CNT_W'(2);
  assign bit_load   = {prescale, 3'b000} - PRESCALE_CNT_W'(1);

  always_comb begin
    phase = rx_phase(prescale_cnt_q == '0, 32'(bit_cnt_q), DATA_WIDTH + 2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tdata_q        <= '0;
      shift_q        <= '0;
      tvalid_q       <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      frame_q        <= 1'b0;
      rxd_q          <= 1'b1;
      prescale_cnt_q <= '0;
      bit_cnt_q      <= '0;
    end else begin
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
      rxd_q     <= rxd;
      if (tvalid_q && output_axis.tready) begin
        tvalid_q <= 1'b0;
      end
      unique case (phase)
        PH_IDLE: begin
          busy_q <= 1'b0;
          if (!rxd_q) begin
            prescale_cnt_q <= start_load;
            bit_cnt_q      <= BIT_CNT_START;
            shift_q        <= '0;
            busy_q         <= 1'b1;
          end
        end
        PH_WAIT: begin
          prescale_cnt_q <= prescale_cnt_q - PRESCALE_CNT_W'(1);
        end
        PH_START: begin
          if (!rxd_q) begin
            bit_cnt_q      <= bit_cnt_q - BIT_CNT_W'(1);
            prescale_cnt_q <= bit_load;
          end else begin
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
          end
        end
        PH_DATA: begin
          bit_cnt_q      <= bit_cnt_q - BIT_CNT_W'(1);
          prescale_cnt_q <= bit_load;
          shift_q        <= {rxd_q, shift_q[DATA_WIDTH-1:1]};
        end
        PH_STOP: begin
          bit_cnt_q <= '0;
          busy_q    <= 1'b0;
          if (rxd_q) begin
            tdata_q   <= shift_q;
            tvalid_q  <= 1'b1;
            // A word consumed in this same cycle is not an overrun.
            overrun_q <= tvalid_q && !output_axis.tready;
          end else begin
            frame_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign output_axis.tdata  = tdata_q;
  assign output_axis.tvalid = tvalid_q;
  assign busy               = busy_q;
  assign overrun_error      = overrun_q;
  assign frame_error        = frame_q;

endmodule

// File: tb/tb_uart_axis_rx.sv
// Bench for uart_axis_rx: frame vector table with a word scoreboard plus hand-written corner sequences.
module tb_uart_axis_rx;

  localparam int unsigned DW = 8;

  typedef struct {
    logic [DW-1:0] data;
    bit            good_stop;
    int unsigned   p;
    int unsigned   exp_words;
    int unsigned   exp_ferr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic        busy;
  logic        ovr;
  logic        ferr;
  logic [15:0] prescale = 16'd1;

  uart_axis_rx_if #(.DATA_WIDTH(DW)) axis ();

  uart_axis_rx #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .output_axis  (axis),
    .rxd          (rxd),
    .busy         (busy),
    .overrun_error(ovr),
    .frame_error  (ferr),
    .prescale     (prescale)
  );

  always #5 clk = ~clk;

  int unsigned   total    = 0;
  int unsigned   passed   = 0;
  int unsigned   words    = 0;
  int unsigned   ovr_cnt  = 0;
  int unsigned   ferr_cnt = 0;
  logic          ovr_prev  = 1'b0;
  logic          ferr_prev = 1'b0;
  logic [DW-1:0] mon_exp;
  logic [DW-1:0] sb[$];
  vec_t          vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drives the first nbits bits of a frame; a bad stop is low for 5/8 of the bit.
  task automatic send_frame(input logic [DW-1:0] d, input bit good_stop,
                            input int unsigned p, input int unsigned nbits);
    logic [DW+1:0] f;
    f = {good_stop ? 1'b1 : 1'b0, d, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      rxd = f[i];
      if (i == 1) check("busy_in_frame", 32'(busy), 32'd1);
      if (i == DW + 1 && !good_stop) begin
        tick(5 * p);
        rxd = 1'b1;
        tick(3 * p);
      end else begin
        tick(8 * p);
      end
    end
    rxd = 1'b1;
  endtask

  // Handshake monitor: pops the scoreboard on every accepted word.
  always @(negedge clk) begin
    if (rst) begin
      if (axis.tvalid && axis.tready) begin
        words++;
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", axis.tdata);
        end else begin
          mon_exp = sb.pop_front();
          check("word", 32'(axis.tdata), 32'(mon_exp));
        end
      end
      if (ovr) begin
        ovr_cnt++;
        check("ovr_pulse_width", 32'(ovr_prev), 32'd0);
      end
      if (ferr) begin
        ferr_cnt++;
        check("ferr_pulse_width", 32'(ferr_prev), 32'd0);
      end
    end
    ovr_prev  = ovr;
    ferr_prev = ferr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0, f0, o0;

    vecs[0] = '{data: 8'h00, good_stop: 1'b1, p: 1, exp_words: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'h01, good_stop: 1'b1, p: 1, exp_words: 1, exp_ferr: 0};
    vecs[2] = '{data: 8'hFF, good_stop: 1'b1, p: 1, exp_words: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'h5A, good_stop: 1'b1, p: 1, exp_words: 1, exp_ferr: 0};
    vecs[4] = '{data: 8'h33, good_stop: 1'b0, p: 2, exp_words: 0, exp_ferr: 1};
    vecs[5] = '{data: 8'h44, good_stop: 1'b1, p: 2, exp_words: 1, exp_ferr: 0};
    vecs[6] = '{data: 8'hC3, good_stop: 1'b1, p: 3, exp_words: 1, exp_ferr: 0};

    // T1: reset values and idle line
    axis.tready = 1'b1;
    #23;
    check("rst_tdata", 32'(axis.tdata), 32'd0);
    check("rst_tvalid", 32'(axis.tvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick(100);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_tvalid", 32'(axis.tvalid), 32'd0);

    // T2/T4: frame table
    foreach (vecs[k]) begin
      prescale = 16'(vecs[k].p);
      w0 = words;
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      if (vecs[k].good_stop) sb.push_back(vecs[k].data);
      send_frame(vecs[k].data, vecs[k].good_stop, vecs[k].p, DW + 2);
      tick(24 * vecs[k].p);
      check("vec_words", words - w0, vecs[k].exp_words);
      check("vec_ferr", ferr_cnt - f0, vecs[k].exp_ferr);
      check("vec_ovr", ovr_cnt - o0, 32'd0);
      check("vec_sb_empty", sb.size(), 32'd0);
      check("vec_busy_after", 32'(busy), 32'd0);
    end

    // T3: overrun with consumer stalled
    prescale = 16'd1;
    axis.tready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1, DW + 2);
    tick(16);
    check("ovr_first_tvalid", 32'(axis.tvalid), 32'd1);
    check("ovr_first_tdata", 32'(axis.tdata), 32'h11);
    check("ovr_none_yet", ovr_cnt - o0, 32'd0);
    sb.push_back(8'h22);
    send_frame(8'h22, 1'b1, 1, DW + 2);
    tick(16);
    check("ovr_pulse", ovr_cnt - o0, 32'd1);
    check("ovr_tdata", 32'(axis.tdata), 32'h22);
    check("ovr_tvalid", 32'(axis.tvalid), 32'd1);
    axis.tready = 1'b1;
    tick(1);
    check("ovr_tvalid_drop", 32'(axis.tvalid), 32'd0);
    check("ovr_sb_empty", sb.size(), 32'd0);

    // T5: two-cycle glitch is rejected at the start check
    prescale = 16'd4;
    w0 = words;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(2);
    check("glitch_busy_rise", 32'(busy), 32'd1);
    tick(40);
    check("glitch_busy_clear", 32'(busy), 32'd0);
    check("glitch_words", words - w0, 32'd0);
    check("glitch_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

    // T6: reset mid-frame, then a clean frame
    prescale = 16'd2;
    send_frame(8'hA5, 1'b1, 2, 4);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tdata", 32'(axis.tdata), 32'd0);
    check("midrst_tvalid", 32'(axis.tvalid), 32'd0);
    rxd = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(10);
    w0 = words;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 2, DW + 2);
    tick(48);
    check("post_rst_words", words - w0, 32'd1);
    check("post_rst_sb_empty", sb.size(), 32'd0);
    check("post_rst_tdata", 32'(axis.tdata), 32'hA5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
